// File: rtl/otter_mem_arb.sv
// Two-port memory arbiter for the OTTER data port: CPU has default priority,
// DMA/programmer port is guaranteed service after STARVE_MAX consecutive CPU wins.
`timescale 1ns/1ps
module otter_mem_arb #(
  parameter int unsigned STARVE_MAX = 4  // legal range 1..15
) (
  input  logic        CLK,
  input  logic        RESET,
  // CPU port
  input  logic        C_REQ,
  input  logic        C_WE,
  input  logic [31:0] C_ADDR,
  input  logic [31:0] C_DIN,
  input  logic [1:0]  C_SIZE,
  input  logic        C_SIGN,
  output logic        C_GNT,
  output logic        C_RVALID,
  output logic [31:0] C_RDATA,
  // DMA / programmer port
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_DIN,
  input  logic [1:0]  D_SIZE,
  input  logic        D_SIGN,
  output logic        D_GNT,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  // memory port 2
  output logic [31:0] M_ADDR,
  output logic [31:0] M_DIN,
  output logic        M_WE,
  output logic        M_RE,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  input  logic [31:0] M_DOUT
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       dma_win;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    C_GNT      = 1'b0;
    D_GNT      = 1'b0;
    starve_nxt = starve_cnt;
    owner_nxt  = OWN_NONE;

    dma_win = D_REQ && (!C_REQ || (starve_cnt == STARVE_LIM));

    // Grants are forced low for the whole reset window, whatever the requests.
    if (!RESET) begin
      D_GNT = dma_win;
      C_GNT = C_REQ && !dma_win;
    end

    if (D_GNT || !D_REQ)
      starve_nxt = '0;
    else if (C_GNT && (starve_cnt < STARVE_LIM))
      starve_nxt = starve_cnt + 4'd1;

    if (C_GNT && !C_WE)
      owner_nxt = OWN_CPU;
    else if (D_GNT && !D_WE)
      owner_nxt = OWN_DMA;
  end

  // Idle cycles leave the CPU fields on the memory bus.
  always_comb begin
    if (D_GNT) begin
      M_ADDR = D_ADDR;
      M_DIN  = D_DIN;
      M_SIZE = D_SIZE;
      M_SIGN = D_SIGN;
    end else begin
      M_ADDR = C_ADDR;
      M_DIN  = C_DIN;
      M_SIZE = C_SIZE;
      M_SIGN = C_SIGN;
    end
    M_WE = (C_GNT && C_WE) || (D_GNT && D_WE);
    M_RE = (C_GNT && !C_WE) || (D_GNT && !D_WE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
    end
  end

  // Memory returns read data one cycle after M_RE; route it to the recorded owner only.
  assign C_RVALID = (owner == OWN_CPU);
  assign D_RVALID = (owner == OWN_DMA);
  assign C_RDATA  = C_RVALID ? M_DOUT : '0;
  assign D_RDATA  = D_RVALID ? M_DOUT : '0;

endmodule

// File: tb/tb_otter_mem_arb.sv
// Self-checking bench for otter_mem_arb: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_otter_mem_arb;

  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        C_REQ, C_WE, C_SIGN, D_REQ, D_WE, D_SIGN;
  logic [31:0] C_ADDR, C_DIN, D_ADDR, D_DIN, M_DOUT;
  logic [1:0]  C_SIZE, D_SIZE;
  logic        C_GNT, C_RVALID, D_GNT, D_RVALID;
  logic [31:0] C_RDATA, D_RDATA, M_ADDR, M_DIN;
  logic        M_WE, M_RE, M_SIGN;
  logic [1:0]  M_SIZE;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: CPU wins counted while DMA waits, and which port owes a read reply.
  int m_wait;
  int m_pend;  // 0 = none, 1 = CPU, 2 = DMA

  otter_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_ADDR(C_ADDR), .C_DIN(C_DIN), .C_SIZE(C_SIZE),
    .C_SIGN(C_SIGN), .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN), .D_SIZE(D_SIZE),
    .D_SIGN(D_SIGN), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WE(M_WE), .M_RE(M_RE), .M_SIZE(M_SIZE),
    .M_SIGN(M_SIGN), .M_DOUT(M_DOUT)
  );

  always #5 CLK = ~CLK;

  // Who should own the bus this cycle: 0 = nobody, 1 = CPU, 2 = DMA.
  function automatic int exp_gnt();
    if (RESET) return 0;
    if (D_REQ && (!C_REQ || m_wait >= STARVE_MAX)) return 2;
    if (C_REQ) return 1;
    return 0;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_wait <= 0;
      m_pend <= 0;
    end else begin
      m_pend <= (exp_gnt() == 1 && !C_WE) ? 1 : (exp_gnt() == 2 && !D_WE) ? 2 : 0;
      if (exp_gnt() == 2 || !D_REQ) m_wait <= 0;
      else if (exp_gnt() == 1 && m_wait < STARVE_MAX) m_wait <= m_wait + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic idle();
    C_REQ = 0; C_WE = 0; C_ADDR = '0; C_DIN = '0; C_SIZE = 2'd2; C_SIGN = 0;
    D_REQ = 0; D_WE = 0; D_ADDR = '0; D_DIN = '0; D_SIZE = 2'd2; D_SIGN = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1; C_REQ = 1; D_REQ = 1; C_WE = 0; D_WE = 0; M_DOUT = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge CLK);
      n_cmp++;
      if ({C_GNT, D_GNT, M_WE, M_RE, C_RVALID, D_RVALID} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_ctrl: got %b want 000000", {C_GNT, D_GNT, M_WE, M_RE, C_RVALID, D_RVALID});
      end
      n_cmp++;
      if ({C_RDATA, D_RDATA, dut.starve_cnt} !== 68'b0) begin
        n_err++;
        $display("FAIL reset_data: got c=%h d=%h starve=%0d want 0", C_RDATA, D_RDATA, dut.starve_cnt);
      end
    end
    idle();
    next_cycle();
    RESET = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    C_REQ = 1; C_WE = 0; C_ADDR = 32'h40; M_DOUT = 32'hCAFE_F00D;
    @(negedge CLK);
    n_cmp++;
    if ({C_GNT, M_RE} !== 2'b11) begin
      n_err++;
      $display("FAIL midread_grant: got gnt/re %b want 11", {C_GNT, M_RE});
    end
    #1 RESET = 1;
    #1;
    n_cmp++;
    if ({C_GNT, D_GNT, M_WE, M_RE, C_RVALID} !== 5'b0) begin
      n_err++;
      $display("FAIL midread_in_reset: got %b want 00000", {C_GNT, D_GNT, M_WE, M_RE, C_RVALID});
    end
    next_cycle();
    C_REQ = 0;
    RESET = 0;
    @(negedge CLK);
    n_cmp++;
    if ({C_RVALID, D_RVALID, C_RDATA} !== 34'b0) begin
      n_err++;
      $display("FAIL midread_after: got rvalid %b rdata %h want 00 0", {C_RVALID, D_RVALID}, C_RDATA);
    end
    next_cycle();
  endtask

  task automatic test_cpu_read();
    C_REQ = 1; C_WE = 0; C_ADDR = 32'h100; C_SIZE = 2'd2;
    @(negedge CLK);
    n_cmp++;
    if ({C_GNT, D_GNT, M_RE, M_WE, M_ADDR} !== {4'b1010, 32'h100}) begin
      n_err++;
      $display("FAIL cpu_read_issue: got gnt/re/we %b addr %h want 1010 100", {C_GNT, D_GNT, M_RE, M_WE}, M_ADDR);
    end
    next_cycle();
    C_REQ = 0; M_DOUT = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_cmp++;
    if ({C_RVALID, D_RVALID, C_RDATA, D_RDATA} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
      n_err++;
      $display("FAIL cpu_read_resp: got v=%b c=%h d=%h want 10 deadbeef 0", {C_RVALID, D_RVALID}, C_RDATA, D_RDATA);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [9:0] dma_turn;
    int starve_exp [6];
    dma_turn = 10'b10_0001_0000;
    starve_exp = '{0, 1, 2, 3, 4, 0};
    C_REQ = 1; C_WE = 1; D_REQ = 1; D_WE = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({C_GNT, D_GNT} !== (dma_turn[i] ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL starve_seq[%0d]: got c/d %b want %b", i, {C_GNT, D_GNT}, dma_turn[i] ? 2'b01 : 2'b10);
      end
      if (i < 6) begin
        n_cmp++;
        if (dut.starve_cnt !== 4'(starve_exp[i])) begin
          n_err++;
          $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dut.starve_cnt, starve_exp[i]);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_dma_write();
    D_REQ = 1; D_WE = 1; D_ADDR = 32'h2000; D_DIN = 32'h1234_5678; D_SIZE = 2'd2;
    C_ADDR = 32'h55; C_DIN = 32'h66; C_SIZE = 2'd0;
    @(negedge CLK);
    n_cmp++;
    if ({C_GNT, D_GNT, M_WE, M_RE, M_ADDR, M_DIN, M_SIZE} !== {4'b0110, 32'h2000, 32'h1234_5678, 2'd2}) begin
      n_err++;
      $display("FAIL dma_write: got ctl %b addr %h din %h size %0d want 0110 2000 12345678 2",
               {C_GNT, D_GNT, M_WE, M_RE}, M_ADDR, M_DIN, M_SIZE);
    end
    next_cycle();
    idle();
    @(negedge CLK);
    n_cmp++;
    if ({C_RVALID, D_RVALID} !== 2'b00) begin
      n_err++;
      $display("FAIL dma_write_norv: got %b want 00", {C_RVALID, D_RVALID});
    end
    next_cycle();
  endtask

  task automatic test_interleaved();
    C_REQ = 1; C_WE = 0; C_ADDR = 32'h10;
    next_cycle();
    C_REQ = 0; D_REQ = 1; D_WE = 0; D_ADDR = 32'h20; M_DOUT = 32'hA;
    @(negedge CLK);
    n_cmp++;
    if ({D_GNT, C_RVALID, D_RVALID, C_RDATA, D_RDATA} !== {3'b110, 32'hA, 32'h0}) begin
      n_err++;
      $display("FAIL inter_n1: got gnt/v %b c=%h d=%h want 110 a 0", {D_GNT, C_RVALID, D_RVALID}, C_RDATA, D_RDATA);
    end
    next_cycle();
    D_REQ = 0; M_DOUT = 32'hB;
    @(negedge CLK);
    n_cmp++;
    if ({C_RVALID, D_RVALID, C_RDATA, D_RDATA} !== {2'b01, 32'h0, 32'hB}) begin
      n_err++;
      $display("FAIL inter_n2: got v %b c=%h d=%h want 01 0 b", {C_RVALID, D_RVALID}, C_RDATA, D_RDATA);
    end
    next_cycle();
  endtask

  task automatic test_fairness_reset();
    C_REQ = 1; C_WE = 1; D_WE = 1;
    for (int i = 0; i < 8; i++) begin
      D_REQ = (i != 2);
      @(negedge CLK);
      n_cmp++;
      if ({C_GNT, D_GNT} !== ((i == 7) ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL fair_seq[%0d]: got c/d %b want %b", i, {C_GNT, D_GNT}, (i == 7) ? 2'b01 : 2'b10);
      end
      if (i == 3) begin
        n_cmp++;
        if (dut.starve_cnt !== 4'd0) begin
          n_err++;
          $display("FAIL fair_cleared: got starve %0d want 0", dut.starve_cnt);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_random(input int cycles);
    bit c_taken = 1;
    bit d_taken = 1;
    int g;
    logic [31:0] e_addr, e_din, e_crd, e_drd;
    logic [1:0]  e_size;
    logic        e_sign;
    for (int i = 0; i < cycles; i++) begin
      // A requester keeps its fields stable until it has been granted.
      if (!C_REQ || c_taken) begin
        C_REQ = ($urandom_range(0, 3) != 0); C_WE = 1'($urandom_range(0, 1));
        C_ADDR = $urandom; C_DIN = $urandom; C_SIZE = 2'($urandom_range(0, 2)); C_SIGN = 1'($urandom_range(0, 1));
      end
      if (!D_REQ || d_taken) begin
        D_REQ = ($urandom_range(0, 2) != 0); D_WE = 1'($urandom_range(0, 1));
        D_ADDR = $urandom; D_DIN = $urandom; D_SIZE = 2'($urandom_range(0, 2)); D_SIGN = 1'($urandom_range(0, 1));
      end
      M_DOUT = $urandom;
      @(negedge CLK);
      g = exp_gnt();
      e_addr = (g == 2) ? D_ADDR : C_ADDR;
      e_din  = (g == 2) ? D_DIN  : C_DIN;
      e_size = (g == 2) ? D_SIZE : C_SIZE;
      e_sign = (g == 2) ? D_SIGN : C_SIGN;
      e_crd  = (m_pend == 1) ? M_DOUT : 32'h0;
      e_drd  = (m_pend == 2) ? M_DOUT : 32'h0;
      n_cmp++;
      if ({C_GNT, D_GNT, M_WE, M_RE} !== {g == 1, g == 2, (g == 1 && C_WE) || (g == 2 && D_WE),
                                          (g == 1 && !C_WE) || (g == 2 && !D_WE)}) begin
        n_err++;
        $display("FAIL rand_ctl[%0d]: got c/d/we/re %b want grant %0d", i, {C_GNT, D_GNT, M_WE, M_RE}, g);
      end
      n_cmp++;
      if ({M_ADDR, M_DIN, M_SIZE, M_SIGN} !== {e_addr, e_din, e_size, e_sign}) begin
        n_err++;
        $display("FAIL rand_bus[%0d]: got %h %h %0d %b want %h %h %0d %b", i, M_ADDR, M_DIN, M_SIZE, M_SIGN,
                 e_addr, e_din, e_size, e_sign);
      end
      n_cmp++;
      if ({C_RVALID, D_RVALID, C_RDATA, D_RDATA} !== {m_pend == 1, m_pend == 2, e_crd, e_drd}) begin
        n_err++;
        $display("FAIL rand_resp[%0d]: got v %b c=%h d=%h want owner %0d c=%h d=%h", i, {C_RVALID, D_RVALID},
                 C_RDATA, D_RDATA, m_pend, e_crd, e_drd);
      end
      c_taken = (g == 1);
      d_taken = (g == 2);
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    idle();
    M_DOUT = '0;
    test_reset();
    test_reset_mid_read();
    test_cpu_read();
    test_starvation();
    test_dma_write();
    test_interleaved();
    test_fairness_reset();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
